mulpop_arbiter: RTL and testbench
=================================

# mulpop_arbiter

Round-robin arbiter and sequencer that shares one 24x24 multiply + popcount datapath among NREQ requesters. Accepts operand pairs over per-requester valid/ready handshakes, issues a start pulse to the datapath, and waits for its done strobe. It then returns the 32-bit product, the ones count and the overflow/error status to the granted requester. It sits between the bus-side register front ends and the shared arithmetic unit.

## Interface
- NREQ, 4, number of requesters (2..8)
- TIMEOUT, 64, max cycles in WAIT before error completion (>=4)

- clk  in  1  clock, all state on rising edge
- n_reset  in  1  asynchronous, active-low reset
- req_valid  in  NREQ  per-requester operand valid
- req_a1  in  24*NREQ  first operand, requester i at [24i+23:24i]
- req_a2  in  24*NREQ  second operand, same packing
- req_ready  out  NREQ  one-hot accept; at most one bit high
- resp_valid  out  NREQ  one-hot response valid to granted requester
- resp_ready  in  NREQ  per-requester response accept
- resp_w  out  32  product bits [31:0]
- resp_l  out  24  ones count of resp_w
- resp_ovf  out  1  product exceeded 32 bits
- resp_err  out  1  datapath timeout
- dp_start  out  1  one-cycle start pulse to datapath
- dp_a1, dp_a2  out  24 each  operands to datapath, stable from ISSUE until RESP exit
- dp_done  in  1  datapath completion strobe
- dp_w  in  32, dp_l  in  24, dp_valid  in  1  datapath results (dp_valid=1: no overflow)
- busy  out  1  high in any state but IDLE
- op_count  out  16  successful completions, wraps 0xFFFF->0
- err_count  out  8  timeouts, saturates at 0xFF

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: winner = first i with req_valid[i]=1, scanning from ptr upward modulo NREQ. req_ready[winner]=1 combinationally. No valid request: req_ready=0, stay IDLE.
- Transfer when req_valid[g] && req_ready[g]: latch g, a1, a2 into dp_a1/dp_a2; go to ISSUE.
- ISSUE: dp_start=1 for exactly one cycle; clear wait counter; go to WAIT.
- WAIT: counter increments each cycle. dp_done=1 latches dp_w, dp_l and resp_ovf=~dp_valid; resp_err=0; go to RESP.
- Timeout: counter reaches TIMEOUT-1 without dp_done. Set resp_w=0, resp_l=0, resp_ovf=0, resp_err=1; err_count+1 (saturating); go to RESP.
- RESP: resp_valid[g]=1; outputs held stable. On resp_ready[g]=1: op_count+1 if resp_err=0; ptr = (g+1) mod NREQ; go to IDLE. resp_ready of other requesters ignored.
- req_ready is 0 outside IDLE; requests pending during an operation wait, and their operands are not sampled.
- dp_done is sampled only in WAIT. Strobes in IDLE, ISSUE or RESP are ignored.
- dp_done and the timeout in the same cycle: dp_done wins, no error.
- Requester dropping req_valid in IDLE before transfer: no grant, no state change.

## Timing
- Reset values: state IDLE, ptr 0, req_ready 0, resp_valid 0, resp_w 0, resp_l 0, resp_ovf 0, resp_err 0, dp_start 0, dp_a1 0, dp_a2 0, busy 0, op_count 0, err_count 0.
- Reset mid-operation aborts immediately. A later dp_done is ignored until a new ISSUE.
- Accept edge to dp_start high: 1 cycle. dp_done (edge N) to resp_valid high: edge N+1.
- Minimum request-to-request throughput: 4 cycles plus datapath latency, with resp_ready tied high.
- Back-to-back requester: after RESP exit, the same requester has lowest priority while others are valid.
- All outputs registered, except req_ready (combinational from req_valid, ptr, state).

## Test plan
- Single request: requester 0 sends a1=0x000003, a2=0x000005; datapath returns 15/4/valid after 3 cycles -> resp_valid=0001, resp_w=0x0000000F, resp_l=4, resp_ovf=0, op_count=1.
- Fairness: all 4 req_valid held high for 8 operations -> grant order 0,1,2,3,0,1,2,3; exactly one req_ready bit high per accept.
- Overflow: a1=a2=0xFFFFFF, datapath dp_valid=0, dp_w=0x00000001 -> resp_ovf=1, resp_w=0x00000001, resp_err=0.
- Timeout: dp_done never asserted -> resp_err=1, resp_w=0 exactly TIMEOUT cycles after ISSUE exit; err_count=1; op_count unchanged.
- Backpressure and stray strobe: resp_ready low for 10 cycles with an extra dp_done pulse in RESP -> outputs stable, no state change, single completion.
- Reset in WAIT, then late dp_done -> all outputs at reset values, state IDLE, ptr 0, no response.

Source files
------------

// File: rtl/mulpop_arbiter.sv
// mulpop_arbiter: round-robin sharing of one multiply+popcount datapath among NREQ requesters
module mulpop_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 n_reset,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [24*NREQ-1:0]   req_a1,
    input  logic [24*NREQ-1:0]   req_a2,
    output logic [NREQ-1:0]      req_ready,
    output logic [NREQ-1:0]      resp_valid,
    input  logic [NREQ-1:0]      resp_ready,
    output logic [31:0]          resp_w,
    output logic [23:0]          resp_l,
    output logic                 resp_ovf,
    output logic                 resp_err,
    output logic                 dp_start,
    output logic [23:0]          dp_a1,
    output logic [23:0]          dp_a2,
    input  logic                 dp_done,
    input  logic [31:0]          dp_w,
    input  logic [23:0]          dp_l,
    input  logic                 dp_valid,
    output logic                 busy,
    output logic [15:0]          op_count,
    output logic [7:0]           err_count
);
    localparam int PW = $clog2(NREQ);
    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t        state, state_next;
    logic [PW-1:0] ptr, g, win;
    logic [CW-1:0] cnt;
    logic          found, accept, done_hit, tmo, resp_take;

    function automatic logic [PW-1:0] rot(input logic [PW-1:0] p, input int k);
        return PW'((int'(p) + k) % NREQ);
    endfunction

    // winner search from ptr upward; scanning downward lets the lowest offset overwrite
    always_comb begin
        win   = '0;
        found = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--)
            if (req_valid[rot(ptr, k)]) begin
                win   = rot(ptr, k);
                found = 1'b1;
            end
    end

    assign req_ready = (state == IDLE && found) ? NREQ'(1) << win : '0;
    assign accept    = state == IDLE && found;
    assign done_hit  = state == WAIT && dp_done;
    assign tmo       = state == WAIT && !dp_done && cnt == CW'(TIMEOUT - 1);
    assign resp_take = state == RESP && resp_ready[g];

    // next-state selection; conditions are mutually exclusive by state
    always_comb begin
        state_next = state;
        state_next = accept              ? ISSUE :
                     state == ISSUE      ? WAIT  :
                     (done_hit || tmo)   ? RESP  :
                     resp_take           ? IDLE  : state;
    end

    // state, datapath operands, response and statistics registers
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state      <= IDLE;
            ptr        <= '0;
            g          <= '0;
            cnt        <= '0;
            busy       <= 1'b0;
            dp_start   <= 1'b0;
            dp_a1      <= '0;
            dp_a2      <= '0;
            resp_valid <= '0;
            resp_w     <= '0;
            resp_l     <= '0;
            resp_ovf   <= 1'b0;
            resp_err   <= 1'b0;
            op_count   <= '0;
            err_count  <= '0;
        end else begin
            state    <= state_next;
            busy     <= state_next != IDLE;
            dp_start <= accept;
            if (accept) begin
                g     <= win;
                dp_a1 <= req_a1[24*win +: 24];
                dp_a2 <= req_a2[24*win +: 24];
            end
            if (state == ISSUE)
                cnt <= '0;
            else if (state == WAIT)
                cnt <= cnt + 1'b1;
            if (done_hit) begin
                resp_w     <= dp_w;
                resp_l     <= dp_l;
                resp_ovf   <= ~dp_valid;
                resp_err   <= 1'b0;
                resp_valid <= NREQ'(1) << g;
            end
            if (tmo) begin
                resp_w     <= '0;
                resp_l     <= '0;
                resp_ovf   <= 1'b0;
                resp_err   <= 1'b1;
                resp_valid <= NREQ'(1) << g;
                err_count  <= err_count + {7'd0, err_count != 8'hFF};
            end
            if (resp_take) begin
                resp_valid <= '0;
                ptr        <= (g == PW'(NREQ - 1)) ? '0 : g + 1'b1;
                if (!resp_err)
                    op_count <= op_count + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_mulpop_arbiter.sv
// tb_mulpop_arbiter: directed self-checking bench for mulpop_arbiter
module tb_mulpop_arbiter;
    localparam int NREQ = 4, TIMEOUT = 64;

    logic              clk = 1'b0, n_reset = 1'b0;
    logic [NREQ-1:0]   req_valid = '0, req_ready, resp_valid, resp_ready = '0;
    logic [24*NREQ-1:0] req_a1 = '0, req_a2 = '0;
    logic [31:0]       resp_w, dp_w = '0;
    logic [23:0]       resp_l, dp_a1, dp_a2, dp_l = '0;
    logic              resp_ovf, resp_err, dp_start, dp_done = 1'b0, dp_valid = 1'b0, busy;
    logic [15:0]       op_count;
    logic [7:0]        err_count;
    int                checks = 0, passes = 0;

    always #5 clk = ~clk;

    mulpop_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .n_reset(n_reset), .req_valid(req_valid), .req_a1(req_a1), .req_a2(req_a2),
        .req_ready(req_ready), .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_w(resp_w),
        .resp_l(resp_l), .resp_ovf(resp_ovf), .resp_err(resp_err), .dp_start(dp_start),
        .dp_a1(dp_a1), .dp_a2(dp_a2), .dp_done(dp_done), .dp_w(dp_w), .dp_l(dp_l),
        .dp_valid(dp_valid), .busy(busy), .op_count(op_count), .err_count(err_count)
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    initial begin
        // reset state
        tick(2);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_ready", 64'(req_ready), 64'd0);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_dp_start", 64'(dp_start), 64'd0);
        chk("rst_counts", 64'({op_count, err_count}), 64'd0);
        n_reset = 1'b1;
        tick(1);

        // single request from requester 0: 3*5
        req_a1[23:0] = 24'h000003;
        req_a2[23:0] = 24'h000005;
        req_valid    = 4'b0001;
        #1 chk("single_ready", 64'(req_ready), 64'b0001);
        tick(1);
        req_valid = '0;
        chk("single_start", 64'(dp_start), 64'd1);
        chk("single_ops", 64'({dp_a1, dp_a2}), 64'({24'h3, 24'h5}));
        chk("single_busy", 64'(busy), 64'd1);
        tick(1);
        chk("single_start_pulse", 64'(dp_start), 64'd0);
        tick(2);
        dp_done = 1'b1; dp_w = 32'h0000000F; dp_l = 24'd4; dp_valid = 1'b1;
        tick(1);
        dp_done = 1'b0;
        chk("single_resp_valid", 64'(resp_valid), 64'b0001);
        chk("single_resp", 64'({resp_w, resp_l, resp_ovf, resp_err}), 64'({32'hF, 24'd4, 2'b00}));
        chk("single_opcnt_pre", 64'(op_count), 64'd0);
        resp_ready = 4'b0001;
        tick(1);
        resp_ready = '0;
        chk("single_opcnt", 64'(op_count), 64'd1);
        chk("single_idle", 64'({busy, resp_valid}), 64'd0);

        // requester raises then drops valid before an edge: no grant
        req_valid = 4'b0010;
        #1 chk("drop_ready", 64'(req_ready), 64'b0010);
        req_valid = '0;
        tick(1);
        chk("drop_busy", 64'(busy), 64'd0);

        // reset while waiting, then a late strobe
        req_a1[71:48] = 24'h11;
        req_a2[71:48] = 24'h22;
        req_valid = 4'b0100;
        tick(1);
        req_valid = '0;
        tick(2);
        chk("rstw_busy_pre", 64'(busy), 64'd1);
        n_reset = 1'b0;
        #1 chk("rstw_async", 64'({busy, dp_start, resp_valid, dp_a1, dp_a2}), 64'd0);
        chk("rstw_counts", 64'({op_count, err_count}), 64'd0);
        tick(1);
        n_reset = 1'b1;
        dp_done = 1'b1; dp_w = 32'h55; dp_l = 24'd4; dp_valid = 1'b1;
        tick(1);
        dp_done = 1'b0;
        tick(3);
        chk("rstw_no_resp", 64'({busy, resp_valid, resp_w}), 64'd0);

        // fairness: all requesters valid, responses always accepted
        req_a1 = {24'h4, 24'h3, 24'h2, 24'h1};
        req_a2 = {24'h40, 24'h30, 24'h20, 24'h10};
        req_valid = '1;
        resp_ready = '1;
        for (int i = 0; i < 8; i++) begin
            int gi;
            gi = i % 4;
            #1 chk("fair_ready", 64'(req_ready), 64'(4'b0001 << gi));
            chk("fair_onehot", 64'($countones(req_ready)), 64'd1);
            tick(1);
            chk("fair_busy_ready", 64'(req_ready), 64'd0);
            chk("fair_ops", 64'({dp_a1, dp_a2}), 64'({24'(gi + 1), 24'(16 * (gi + 1))}));
            tick(1);
            dp_done = 1'b1; dp_w = 32'(16 * (gi + 1) * (gi + 1)); dp_l = 24'(gi); dp_valid = 1'b1;
            tick(1);
            dp_done = 1'b0;
            chk("fair_resp_valid", 64'(resp_valid), 64'(4'b0001 << gi));
            chk("fair_resp_w", 64'(resp_w), 64'(16 * (gi + 1) * (gi + 1)));
            tick(1);
        end
        req_valid = '0;
        resp_ready = '0;
        chk("fair_opcnt", 64'(op_count), 64'd8);

        // overflow reported by datapath
        req_a1[47:24] = 24'hFFFFFF;
        req_a2[47:24] = 24'hFFFFFF;
        req_valid = 4'b0010;
        tick(1);
        req_valid = '0;
        chk("ovf_ops", 64'({dp_a1, dp_a2}), 64'({24'hFFFFFF, 24'hFFFFFF}));
        tick(1);
        dp_done = 1'b1; dp_w = 32'h1; dp_l = 24'd1; dp_valid = 1'b0;
        tick(1);
        dp_done = 1'b0;
        chk("ovf_resp_valid", 64'(resp_valid), 64'b0010);
        chk("ovf_resp", 64'({resp_w, resp_ovf, resp_err}), 64'({32'h1, 2'b10}));
        resp_ready = 4'b0010;
        tick(1);
        resp_ready = '0;
        chk("ovf_opcnt", 64'(op_count), 64'd9);

        // timeout: no strobe from datapath
        req_valid = 4'b0100;
        tick(1);
        req_valid = '0;
        tick(1);
        tick(TIMEOUT - 1);
        chk("tmo_early", 64'({resp_valid, resp_err}), 64'd0);
        tick(1);
        chk("tmo_resp_valid", 64'(resp_valid), 64'b0100);
        chk("tmo_resp", 64'({resp_w, resp_l, resp_ovf, resp_err}), 64'd1);
        chk("tmo_errcnt", 64'(err_count), 64'd1);
        resp_ready = 4'b0100;
        tick(1);
        resp_ready = '0;
        chk("tmo_opcnt", 64'(op_count), 64'd9);

        // backpressure, stray strobe in RESP, other resp_ready bits ignored
        req_valid = 4'b1000;
        tick(1);
        req_valid = '0;
        tick(1);
        dp_done = 1'b1; dp_w = 32'h3F; dp_l = 24'd6; dp_valid = 1'b1;
        tick(1);
        dp_done = 1'b0;
        resp_ready = 4'b0111;
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                dp_done = 1'b1; dp_w = 32'hDEAD; dp_l = 24'd9; dp_valid = 1'b0;
            end
            tick(1);
            dp_done = 1'b0;
            chk("bp_hold", 64'({resp_valid, resp_w, resp_l[7:0], resp_ovf, resp_err, busy}),
                64'({4'b1000, 32'h3F, 8'd6, 3'b001}));
        end
        resp_ready = 4'b1000;
        tick(1);
        resp_ready = '0;
        chk("bp_done", 64'({resp_valid, busy}), 64'd0);
        chk("bp_opcnt", 64'(op_count), 64'd10);
        tick(3);
        chk("bp_single", 64'({resp_valid, op_count}), 64'(16'd10));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
